sd_read_arbiter: RTL
====================

Name: sd_read_arbiter

Overview:
- Shares the single SD block reader between two requesters: port A (MP3 audio stream, latency-critical) and port B (graphics/asset loader).
- Sits between the SD controller and the MP3 communicator/asset loader. It sequences each block read as request, acknowledge, busy, done.
- The 4096-bit SD read data bus is broadcast to both clients. The arbiter tells each client when the data on that bus is its own.
- Port A has fixed priority, with a burst limit so that port B cannot starve.

Parameters:
- MAX_A_BURST, 4, consecutive A grants allowed while B is waiting before B is forced next (1..15).
- ACK_TIMEOUT, 1000, cycles to wait in ISSUE for SD_IS_READING to rise before aborting the read (fits 16 bits).

Ports:
- CLK  input  1  system clock; all logic on rising edge.
- RESET  input  1  synchronous reset, active-high.
- SD_HAS_INITIALIZED  input  1  SD controller ready.
- SD_IS_READING  input  1  SD controller busy with a block read.
- SD_TO_READ  output  1  read request to SD controller.
- SD_READ_ADDRESS  output  32  block address to SD controller.
- REQ_A / REQ_B  input  1 each  level request; held high while a read is wanted.
- ADDR_A / ADDR_B  input  32 each  block address; sampled only on the grant cycle.
- GRANT_A / GRANT_B  output  1 each  one-cycle pulse when the request is accepted.
- BUSY_A / BUSY_B  output  1 each  high from the grant until DONE/ERR inclusive.
- DONE_A / DONE_B  output  1 each  one-cycle pulse; SD_READ_DATA is valid for this owner.
- ERR_A / ERR_B  output  1 each  one-cycle pulse; acknowledge timeout, no data.

Behaviour:
- Reset values:
  - state = WAIT_INIT.
  - All outputs = 0, SD_READ_ADDRESS = 0.
  - burst counter = 0, timeout counter = 0, owner = A.
- RESET asserted mid-operation aborts at once to WAIT_INIT. No DONE/ERR is emitted for the aborted read.
- Every output is registered.
- WAIT_INIT:
  - Outputs stay idle.
  - Go to IDLE on the first cycle SD_HAS_INITIALIZED = 1.
- IDLE, arbitration:
  - Only A requesting: grant A.
  - Only B requesting: grant B.
  - Both requesting: grant A unless burst counter == MAX_A_BURST, in which case grant B.
- Burst counter rules:
  - Increments on an A grant made while REQ_B = 1, saturating at MAX_A_BURST.
  - Clears on any B grant.
  - Clears on an A grant made while REQ_B = 0.
- Grant cycle (the IDLE cycle in which a request is chosen):
  - GRANT_x pulses high for that cycle.
  - ADDR_x is latched into SD_READ_ADDRESS and the owner is recorded.
  - Next state is ISSUE.
  - BUSY_x rises in the same cycle as GRANT_x.
- ISSUE:
  - SD_TO_READ = 1 and SD_READ_ADDRESS is held stable.
  - When SD_IS_READING = 1 is sampled: SD_TO_READ drops on the next edge and the state goes to BUSY.
  - If the timeout counter reaches ACK_TIMEOUT first: SD_TO_READ drops, ERR_owner pulses, and the state goes to IDLE.
- BUSY:
  - SD_TO_READ = 0.
  - Wait for SD_IS_READING = 0, then go to DONE.
- DONE (single cycle):
  - DONE_owner = 1; BUSY_owner is still 1 in this cycle.
  - Next state is IDLE; BUSY_owner falls.
- Minimum latency:
  - Grant to SD_TO_READ high: 1 cycle.
  - SD_IS_READING falling to DONE pulse: 1 cycle.
  - DONE to next GRANT: 1 cycle (through IDLE).
- Requests arriving while not in IDLE wait. A request that stays high after its DONE is treated as a new request.
- If SD_HAS_INITIALIZED falls while not in WAIT_INIT, it is ignored; the reset path handles re-initialisation.
- Exactly one of GRANT, DONE or ERR may pulse per cycle, and only for the current owner.

Test Plan:
- Reset/init:
  - Stimulus: hold SD_HAS_INITIALIZED = 0 for 20 cycles with REQ_A = 1.
  - Required: no GRANT and SD_TO_READ = 0 throughout. GRANT_A comes 1 cycle after init rises; SD_TO_READ = 1 one cycle later with SD_READ_ADDRESS = ADDR_A (0x0000_1000).
- Single read A:
  - Stimulus: SD model raises SD_IS_READING 3 cycles after SD_TO_READ, stays busy 50 cycles.
  - Required: SD_TO_READ drops the cycle after the rise. DONE_A pulses exactly once, 1 cycle after the fall. BUSY_A spans GRANT_A through DONE_A.
- Contention/burst:
  - Stimulus: REQ_A and REQ_B held high continuously, MAX_A_BURST = 4.
  - Required: grant order A, A, A, A, B, A, A, A, A, B; addresses match their owners.
- Timeout:
  - Stimulus: SD_IS_READING never rises, ACK_TIMEOUT = 1000.
  - Required: ERR_x pulses, SD_TO_READ drops, the arbiter returns to IDLE, and a pending B request is then granted.
- Reset mid-read:
  - Stimulus: assert RESET during BUSY.
  - Required: next cycle all outputs = 0 and state = WAIT_INIT; no DONE pulse.
- Address stability:
  - Stimulus: change ADDR_A during ISSUE/BUSY.
  - Required: SD_READ_ADDRESS stays at the value latched on the grant cycle.

Source files
------------

// File: rtl/sd_read_arbiter.sv
// Shares the single SD block reader between the MP3 stream (port A, priority)
// and the asset loader (port B), sequencing request/ack/busy/done per read.
module sd_read_arbiter #(
  parameter int MAX_A_BURST = 4,
  parameter int ACK_TIMEOUT = 1000
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        SD_HAS_INITIALIZED,
  input  logic        SD_IS_READING,
  output logic        SD_TO_READ,
  output logic [31:0] SD_READ_ADDRESS,
  input  logic        REQ_A,
  input  logic        REQ_B,
  input  logic [31:0] ADDR_A,
  input  logic [31:0] ADDR_B,
  output logic        GRANT_A,
  output logic        GRANT_B,
  output logic        BUSY_A,
  output logic        BUSY_B,
  output logic        DONE_A,
  output logic        DONE_B,
  output logic        ERR_A,
  output logic        ERR_B
);

  typedef enum logic [2:0] {
    ST_WAIT_INIT,
    ST_IDLE,
    ST_ISSUE,
    ST_BUSY,
    ST_DONE
  } state_t;

  localparam logic [3:0]  BURST_MAX    = 4'(MAX_A_BURST);
  localparam logic [15:0] TIMEOUT_LAST = 16'(ACK_TIMEOUT - 1);

  state_t      state, state_n;
  logic        owner_b, owner_b_n;
  logic [3:0]  burst_cnt, burst_cnt_n;
  logic [15:0] timeout_cnt, timeout_cnt_n;
  logic        to_read_n;
  logic [31:0] addr_n;
  logic        grant_a_n, grant_b_n;
  logic        busy_a_n, busy_b_n;
  logic        done_a_n, done_b_n;
  logic        err_a_n, err_b_n;
  logic        pick_a;

  // A wins unless B is waiting and A has used up its burst allowance.
  assign pick_a = REQ_A && (!REQ_B || (burst_cnt != BURST_MAX));

  always_comb begin
    state_n       = state;
    owner_b_n     = owner_b;
    burst_cnt_n   = burst_cnt;
    timeout_cnt_n = timeout_cnt;
    to_read_n     = 1'b0;
    addr_n        = SD_READ_ADDRESS;
    grant_a_n     = 1'b0;
    grant_b_n     = 1'b0;
    busy_a_n      = BUSY_A;
    busy_b_n      = BUSY_B;
    done_a_n      = 1'b0;
    done_b_n      = 1'b0;
    err_a_n       = 1'b0;
    err_b_n       = 1'b0;

    unique case (state)
      ST_WAIT_INIT: begin
        busy_a_n = 1'b0;
        busy_b_n = 1'b0;
        if (SD_HAS_INITIALIZED) begin
          state_n = ST_IDLE;
        end
      end

      ST_IDLE: begin
        busy_a_n      = 1'b0;
        busy_b_n      = 1'b0;
        timeout_cnt_n = 16'd0;
        if (pick_a) begin
          grant_a_n   = 1'b1;
          busy_a_n    = 1'b1;
          addr_n      = ADDR_A;
          owner_b_n   = 1'b0;
          burst_cnt_n = REQ_B ? burst_cnt + 4'd1 : 4'd0;
          state_n     = ST_ISSUE;
        end else if (REQ_B) begin
          grant_b_n   = 1'b1;
          busy_b_n    = 1'b1;
          addr_n      = ADDR_B;
          owner_b_n   = 1'b1;
          burst_cnt_n = 4'd0;
          state_n     = ST_ISSUE;
        end
      end

      ST_ISSUE: begin
        if (SD_IS_READING) begin
          state_n = ST_BUSY;
        end else if (timeout_cnt == TIMEOUT_LAST) begin
          err_a_n = !owner_b;
          err_b_n = owner_b;
          state_n = ST_IDLE;
        end else begin
          to_read_n     = 1'b1;
          timeout_cnt_n = timeout_cnt + 16'd1;
        end
      end

      ST_BUSY: begin
        if (!SD_IS_READING) begin
          done_a_n = !owner_b;
          done_b_n = owner_b;
          state_n  = ST_DONE;
        end
      end

      ST_DONE: begin
        busy_a_n = 1'b0;
        busy_b_n = 1'b0;
        state_n  = ST_IDLE;
      end

      default: begin
        state_n = ST_WAIT_INIT;
      end
    endcase
  end

  // Every output is a flop so clients see clean pulses.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state           <= ST_WAIT_INIT;
      owner_b         <= 1'b0;
      burst_cnt       <= 4'd0;
      timeout_cnt     <= 16'd0;
      SD_TO_READ      <= 1'b0;
      SD_READ_ADDRESS <= 32'd0;
      GRANT_A         <= 1'b0;
      GRANT_B         <= 1'b0;
      BUSY_A          <= 1'b0;
      BUSY_B          <= 1'b0;
      DONE_A          <= 1'b0;
      DONE_B          <= 1'b0;
      ERR_A           <= 1'b0;
      ERR_B           <= 1'b0;
    end else begin
      state           <= state_n;
      owner_b         <= owner_b_n;
      burst_cnt       <= burst_cnt_n;
      timeout_cnt     <= timeout_cnt_n;
      SD_TO_READ      <= to_read_n;
      SD_READ_ADDRESS <= addr_n;
      GRANT_A         <= grant_a_n;
      GRANT_B         <= grant_b_n;
      BUSY_A          <= busy_a_n;
      BUSY_B          <= busy_b_n;
      DONE_A          <= done_a_n;
      DONE_B          <= done_b_n;
      ERR_A           <= err_a_n;
      ERR_B           <= err_b_n;
    end
  end

endmodule
